// File: rtl/fft_stage_ctrl_pkg.sv
// Shared definitions for the radix-2 DIT FFT stage sequencer.
//   STAGE_W    width of the stage index port
//   LOG2N_DEF  default transform size (log2)
//   OVF_W      number of kernel overflow lanes
//   OVF_CNT_W  width of the optional overflow-cycle counter
//   fsm_state_t  sequencer states IDLE/RUN/DRAIN/DONE
package fft_stage_ctrl_pkg;

  localparam int STAGE_W   = 4;
  localparam int LOG2N_DEF = 8;
  localparam int OVF_W     = 4;
  localparam int OVF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fft_stage_ctrl_addr_gen.sv
// fft_addr_gen: combinational butterfly address generator.
// For stage s (span h = 1<<s) and butterfly index j it returns
//   a  = j with a zero bit inserted at position s
//   b  = a + h (the same index with bit s set)
//   tw = (j mod h) scaled to the N/2-entry twiddle table
// Ports:
//   stage_i  in  STAGE_W   stage index (values >= LOG2N yield all-zero outputs)
//   j_i      in  LOG2N-1   butterfly index within the stage
//   a_o      out LOG2N     x1 sample address
//   b_o      out LOG2N     x2 sample address
//   tw_o     out LOG2N-1   twiddle index k of W_N^k
module fft_addr_gen
  import fft_stage_ctrl_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic [STAGE_W-1:0] stage_i,
  input  logic [LOG2N-2:0]   j_i,
  output logic [LOG2N-1:0]   a_o,
  output logic [LOG2N-1:0]   b_o,
  output logic [LOG2N-2:0]   tw_o
);

  logic [LOG2N-1:0]   j_ext;
  logic [LOG2N-1:0]   span;
  logic [LOG2N-1:0]   low_mask;
  logic [LOG2N-1:0]   addr_a;
  logic [LOG2N-2:0]   tw;
  logic [STAGE_W-1:0] tw_shift;

  always_comb begin
    j_ext    = {1'b0, j_i};
    span     = '0;
    low_mask = '0;
    addr_a   = '0;
    tw       = '0;
    tw_shift = '0;
    if (int'(stage_i) < LOG2N) begin
      span     = LOG2N'(1) << stage_i;
      low_mask = span - LOG2N'(1);
      // Upper bits of j move up one place to open a hole at bit s.
      addr_a   = (((j_ext >> stage_i) << 1) << stage_i) | (j_ext & low_mask);
      tw_shift = STAGE_W'(LOG2N - 1) - stage_i;
      tw       = (j_i & low_mask[LOG2N-2:0]) << tw_shift;
    end
  end

  // Bit s of addr_a is always clear, so OR is the same as adding the span.
  assign a_o  = addr_a;
  assign b_o  = addr_a | span;
  assign tw_o = tw;

endmodule

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: sequencer for an in-place radix-2 DIT FFT.
// Walks LOG2N stages of N/2 butterflies, issuing one (x1,x2) read pair
// and twiddle index per cycle, then idles KERNEL_LAT cycles so the last
// write-back of a stage lands before the next stage reads it. Write-back
// addresses are the read addresses delayed by KERNEL_LAT cycles.
// Optional feature macro: FFT_OVF_CNT_EN adds ovf_cnt_o, a saturating
// count of write-back cycles that raised any overflow flag.
// Ports:
//   clk_i         in   clock
//   rst_n_i       in   asynchronous active-low reset
//   start_i       in   start a transform (only honoured in IDLE)
//   busy_o        out  high from start accept through the done_o cycle
//   done_o        out  one-cycle completion pulse
//   stage_o       out  current stage index
//   rd_en_o       out  sample-RAM read strobe
//   rd_addr_a_o   out  x1 read address
//   rd_addr_b_o   out  x2 read address
//   tw_addr_o     out  twiddle ROM index
//   wr_en_o       out  write-back strobe
//   wr_addr_a_o   out  X1 write address
//   wr_addr_b_o   out  X2 write address
//   ovf_i         in   kernel overflow flags, aligned with wr_en_o
//   ovf_sticky_o  out  OR of ovf_i over the write-backs of the current/last run
//   ovf_cnt_o     out  (FFT_OVF_CNT_EN only) overflowing write-back count
module fft_stage_ctrl
  import fft_stage_ctrl_pkg::*;
#(
  parameter int LOG2N      = LOG2N_DEF,
  parameter int KERNEL_LAT = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [STAGE_W-1:0]   stage_o,
  output logic                 rd_en_o,
  output logic [LOG2N-1:0]     rd_addr_a_o,
  output logic [LOG2N-1:0]     rd_addr_b_o,
  output logic [LOG2N-2:0]     tw_addr_o,
  output logic                 wr_en_o,
  output logic [LOG2N-1:0]     wr_addr_a_o,
  output logic [LOG2N-1:0]     wr_addr_b_o,
  input  logic [OVF_W-1:0]     ovf_i,
  output logic [OVF_W-1:0]     ovf_sticky_o
`ifdef FFT_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_cnt_o
`endif
);

  localparam int                 J_W        = LOG2N - 1;
  localparam logic [J_W-1:0]     J_LAST     = '1;
  localparam int                 DRN_W      = $clog2(KERNEL_LAT + 1);
  localparam logic [DRN_W-1:0]   DRN_LOAD   = DRN_W'(KERNEL_LAT);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);

  fsm_state_t         state_q;
  logic [J_W-1:0]     j_q;
  logic [DRN_W-1:0]   drn_q;
  logic               start_acc;

  logic [STAGE_W-1:0] gen_stage;
  logic [J_W-1:0]     gen_j;
  logic [LOG2N-1:0]   gen_a;
  logic [LOG2N-1:0]   gen_b;
  logic [J_W-1:0]     gen_tw;

  logic               vld_p  [KERNEL_LAT];
  logic [LOG2N-1:0]   addr_a_p [KERNEL_LAT];
  logic [LOG2N-1:0]   addr_b_p [KERNEL_LAT];

  assign start_acc = (state_q == ST_IDLE) && start_i;

  // The address generator is fed the (stage, j) pair that will be on the
  // read port in the next cycle, so the read outputs can be registered
  // on the same edge that advances the counters.
  always_comb begin
    gen_stage = '0;
    gen_j     = '0;
    case (state_q)
      ST_RUN: begin
        gen_stage = stage_o;
        gen_j     = j_q + J_W'(1);
      end
      ST_DRAIN: begin
        gen_stage = stage_o + STAGE_W'(1);
      end
      default: begin
        gen_stage = '0;
        gen_j     = '0;
      end
    endcase
  end

  fft_addr_gen #(
    .LOG2N (LOG2N)
  ) u_addr_gen (
    .stage_i (gen_stage),
    .j_i     (gen_j),
    .a_o     (gen_a),
    .b_o     (gen_b),
    .tw_o    (gen_tw)
  );

  // ---- stage p0: sequencer FSM and registered read port ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      stage_o     <= '0;
      j_q         <= '0;
      drn_q       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_a_o <= '0;
      rd_addr_b_o <= '0;
      tw_addr_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q     <= ST_RUN;
            busy_o      <= 1'b1;
            stage_o     <= '0;
            j_q         <= '0;
            rd_en_o     <= 1'b1;
            rd_addr_a_o <= gen_a;
            rd_addr_b_o <= gen_b;
            tw_addr_o   <= gen_tw;
          end
        end
        ST_RUN: begin
          if (j_q == J_LAST) begin
            state_q <= ST_DRAIN;
            drn_q   <= DRN_LOAD;
            rd_en_o <= 1'b0;
          end else begin
            j_q         <= gen_j;
            rd_en_o     <= 1'b1;
            rd_addr_a_o <= gen_a;
            rd_addr_b_o <= gen_b;
            tw_addr_o   <= gen_tw;
          end
        end
        ST_DRAIN: begin
          // Exactly KERNEL_LAT idle read cycles, so the first read of the
          // next stage comes one cycle after the last write of this one.
          if (drn_q == DRN_W'(1)) begin
            if (stage_o == STAGE_LAST) begin
              state_q <= ST_DONE;
              done_o  <= 1'b1;
            end else begin
              state_q     <= ST_RUN;
              stage_o     <= gen_stage;
              j_q         <= '0;
              rd_en_o     <= 1'b1;
              rd_addr_a_o <= gen_a;
              rd_addr_b_o <= gen_b;
              tw_addr_o   <= gen_tw;
            end
          end else begin
            drn_q <= drn_q - DRN_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---- stages p1..pKERNEL_LAT: write-back address delay line ----
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < KERNEL_LAT; i++) begin
        vld_p[i]    <= 1'b0;
        addr_a_p[i] <= '0;
        addr_b_p[i] <= '0;
      end
    end else begin
      vld_p[0]    <= rd_en_o;
      addr_a_p[0] <= rd_addr_a_o;
      addr_b_p[0] <= rd_addr_b_o;
      for (int i = 1; i < KERNEL_LAT; i++) begin
        vld_p[i]    <= vld_p[i-1];
        addr_a_p[i] <= addr_a_p[i-1];
        addr_b_p[i] <= addr_b_p[i-1];
      end
    end
  end

  assign wr_en_o     = vld_p[KERNEL_LAT-1];
  assign wr_addr_a_o = addr_a_p[KERNEL_LAT-1];
  assign wr_addr_b_o = addr_b_p[KERNEL_LAT-1];

  // ---- write-back side: overflow collection ----
  // Flags are only meaningful while a write-back is on the bus.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_sticky_o <= '0;
    end else if (start_acc) begin
      ovf_sticky_o <= '0;
    end else if (wr_en_o) begin
      ovf_sticky_o <= ovf_sticky_o | ovf_i;
    end
  end

`ifdef FFT_OVF_CNT_EN
  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (&v) ? v : v + OVF_CNT_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_cnt_o <= '0;
    end else if (start_acc) begin
      ovf_cnt_o <= '0;
    end else if (wr_en_o && (|ovf_i)) begin
      ovf_cnt_o <= sat_inc(ovf_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl at LOG2N=3, KERNEL_LAT=3.
// Expected per-cycle behaviour comes from a reference schedule built from
// the butterfly pairing rule (every index with bit s clear pairs with the
// index h above it), plus a constant table of the documented address list.
module tb_fft_stage_ctrl;

  localparam int LOG2N = 3;
  localparam int KL    = 3;
  localparam int N     = 1 << LOG2N;
  localparam int P     = N / 2 + KL;
  localparam int L     = LOG2N * P + 1;
  localparam int MAXC  = 64;

  logic             clk = 1'b0;
  logic             rst_n_i;
  logic             start_i;
  logic             busy_o;
  logic             done_o;
  logic [3:0]       stage_o;
  logic             rd_en_o;
  logic [LOG2N-1:0] rd_addr_a_o;
  logic [LOG2N-1:0] rd_addr_b_o;
  logic [LOG2N-2:0] tw_addr_o;
  logic             wr_en_o;
  logic [LOG2N-1:0] wr_addr_a_o;
  logic [LOG2N-1:0] wr_addr_b_o;
  logic [3:0]       ovf_i;
  logic [3:0]       ovf_sticky_o;
`ifdef FFT_OVF_CNT_EN
  logic [15:0]      ovf_cnt_o;
`endif

  fft_stage_ctrl #(
    .LOG2N      (LOG2N),
    .KERNEL_LAT (KL)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .stage_o      (stage_o),
    .rd_en_o      (rd_en_o),
    .rd_addr_a_o  (rd_addr_a_o),
    .rd_addr_b_o  (rd_addr_b_o),
    .tw_addr_o    (tw_addr_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_a_o  (wr_addr_a_o),
    .wr_addr_b_o  (wr_addr_b_o),
    .ovf_i        (ovf_i),
    .ovf_sticky_o (ovf_sticky_o)
`ifdef FFT_OVF_CNT_EN
    ,
    .ovf_cnt_o    (ovf_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference schedule, indexed by cycle number after the start edge.
  int e_rd [MAXC];
  int e_a  [MAXC];
  int e_b  [MAXC];
  int e_tw [MAXC];
  int e_wr [MAXC];
  int e_wa [MAXC];
  int e_wb [MAXC];
  int e_done  [MAXC];
  int e_busy  [MAXC];
  int e_stage [MAXC];
  logic [3:0] e_sticky;
  int e_cnt;

  // Captured DUT read/write ports of the most recent run.
  int c_rd [MAXC];
  int c_a  [MAXC];
  int c_b  [MAXC];
  int c_tw [MAXC];
  int c_wr [MAXC];
  int c_wa [MAXC];
  int c_wb [MAXC];

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic void build_model();
    int c;
    int h;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_a[i] = 0; e_b[i] = 0; e_tw[i] = 0;
      e_wr[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
      e_done[i] = 0; e_busy[i] = 0; e_stage[i] = 0;
    end
    c = 1;
    for (int s = 0; s < LOG2N; s++) begin
      h = 1 << s;
      for (int x = 0; x < N; x++) begin
        if (((x >> s) & 1) == 0) begin
          e_rd[c] = 1; e_a[c] = x; e_b[c] = x + h; e_tw[c] = (x % h) * (N / (2 * h));
          e_wr[c+KL] = 1; e_wa[c+KL] = x; e_wb[c+KL] = x + h;
          c++;
        end
      end
      c += KL;
    end
    e_done[c] = 1;
    for (int i = 1; i <= c; i++) e_busy[i] = 1;
    for (int i = 1; i < c; i++) e_stage[i] = (i - 1) / P;
    e_stage[c] = LOG2N - 1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, busy_o, 0);
    chk({tag, " done"}, done_o, 0);
    chk({tag, " stage"}, stage_o, 0);
    chk({tag, " rd_en"}, rd_en_o, 0);
    chk({tag, " rd_a"}, rd_addr_a_o, 0);
    chk({tag, " rd_b"}, rd_addr_b_o, 0);
    chk({tag, " tw"}, tw_addr_o, 0);
    chk({tag, " wr_en"}, wr_en_o, 0);
    chk({tag, " wr_a"}, wr_addr_a_o, 0);
    chk({tag, " wr_b"}, wr_addr_b_o, 0);
    chk({tag, " sticky"}, ovf_sticky_o, 0);
`ifdef FFT_OVF_CNT_EN
    chk({tag, " ovf_cnt"}, ovf_cnt_o, 0);
`endif
  endtask

  // mode 0: documented overflow pattern and an ignored start at cycle 9
  // mode 1: random ovf_i every cycle and random start pulses during the run
  // mode 2: constant ovf_i, reset asserted in cycle rst_cyc
  task automatic run_fft(input int mode, input int rst_cyc);
    e_sticky = 4'b0000;
    e_cnt    = 0;
    @(negedge clk);
    start_i = 1'b1;
    for (int c = 1; c <= L + 2; c++) begin
      @(negedge clk);
      c_rd[c] = rd_en_o; c_a[c] = rd_addr_a_o; c_b[c] = rd_addr_b_o; c_tw[c] = tw_addr_o;
      c_wr[c] = wr_en_o; c_wa[c] = wr_addr_a_o; c_wb[c] = wr_addr_b_o;
      chk($sformatf("m%0d rd_en c%0d", mode, c), rd_en_o, e_rd[c]);
      chk($sformatf("m%0d wr_en c%0d", mode, c), wr_en_o, e_wr[c]);
      chk($sformatf("m%0d busy c%0d", mode, c), busy_o, e_busy[c]);
      chk($sformatf("m%0d done c%0d", mode, c), done_o, e_done[c]);
      if (c <= L) chk($sformatf("m%0d stage c%0d", mode, c), stage_o, e_stage[c]);
      if (e_rd[c] != 0) begin
        chk($sformatf("m%0d rd_a c%0d", mode, c), rd_addr_a_o, e_a[c]);
        chk($sformatf("m%0d rd_b c%0d", mode, c), rd_addr_b_o, e_b[c]);
        chk($sformatf("m%0d tw c%0d", mode, c), tw_addr_o, e_tw[c]);
      end
      if (e_wr[c] != 0) begin
        chk($sformatf("m%0d wr_a c%0d", mode, c), wr_addr_a_o, e_wa[c]);
        chk($sformatf("m%0d wr_b c%0d", mode, c), wr_addr_b_o, e_wb[c]);
      end
      chk($sformatf("m%0d sticky c%0d", mode, c), ovf_sticky_o, e_sticky);
`ifdef FFT_OVF_CNT_EN
      chk($sformatf("m%0d ovf_cnt c%0d", mode, c), ovf_cnt_o, e_cnt);
`endif
      if (rst_cyc != 0 && c == rst_cyc) begin
        rst_n_i = 1'b0;
        #1;
        chk_all_zero($sformatf("rst c%0d", c));
        repeat (2) @(negedge clk);
        chk_all_zero("rst held");
        rst_n_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk_all_zero($sformatf("after rst +%0d", k));
        end
        ovf_i   = 4'b0000;
        start_i = 1'b0;
        return;
      end
      if (mode == 0) begin
        ovf_i   = (c == 11) ? 4'b0010 : (c == 19) ? 4'b1000 : 4'b0000;
        start_i = (c == 9);
      end else if (mode == 1) begin
        ovf_i   = 4'($urandom_range(0, 15));
        start_i = (c <= L) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end else begin
        ovf_i   = 4'b0101;
        start_i = 1'b0;
      end
      if (e_wr[c] != 0) begin
        e_sticky = e_sticky | ovf_i;
        if (ovf_i != 4'b0000) e_cnt++;
      end
    end
    ovf_i   = 4'b0000;
    start_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0;
    start_i = 1'b0;
    ovf_i   = 4'b0000;
    build_model();

    tbl[0]  = '{1,  0, 1, 0};
    tbl[1]  = '{2,  2, 3, 0};
    tbl[2]  = '{3,  4, 5, 0};
    tbl[3]  = '{4,  6, 7, 0};
    tbl[4]  = '{8,  0, 2, 0};
    tbl[5]  = '{9,  1, 3, 2};
    tbl[6]  = '{10, 4, 6, 0};
    tbl[7]  = '{11, 5, 7, 2};
    tbl[8]  = '{15, 0, 4, 0};
    tbl[9]  = '{16, 1, 5, 1};
    tbl[10] = '{17, 2, 6, 2};
    tbl[11] = '{18, 3, 7, 3};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("idle after reset");

    run_fft(0, 0);
    chk("sticky after done", ovf_sticky_o, 4'b1010);
`ifdef FFT_OVF_CNT_EN
    chk("ovf_cnt after done", ovf_cnt_o, 2);
`endif
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tbl%0d rd_en", i), c_rd[tbl[i].cyc], 1);
      chk($sformatf("tbl%0d rd_a", i), c_a[tbl[i].cyc], tbl[i].a);
      chk($sformatf("tbl%0d rd_b", i), c_b[tbl[i].cyc], tbl[i].b);
      chk($sformatf("tbl%0d tw", i), c_tw[tbl[i].cyc], tbl[i].tw);
      chk($sformatf("tbl%0d wr_en", i), c_wr[tbl[i].cyc + KL], 1);
      chk($sformatf("tbl%0d wr_a", i), c_wa[tbl[i].cyc + KL], tbl[i].a);
      chk($sformatf("tbl%0d wr_b", i), c_wb[tbl[i].cyc + KL], tbl[i].b);
    end
    begin
      int nrd;
      nrd = 0;
      for (int c = 1; c <= L + 2; c++) nrd += c_rd[c];
      chk("total reads", nrd, 12);
    end
    @(negedge clk);
    chk("sticky hold", ovf_sticky_o, 4'b1010);

    run_fft(0, 0);
    repeat (3) run_fft(1, 0);
    run_fft(2, 10);
    run_fft(0, 0);
    chk("sticky after post-reset run", ovf_sticky_o, 4'b1010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
